// File: rtl/branch_predictor_pkg.sv
// Shared types for the fetch-side branch predictor.
//   bht_cnt_e : 2-bit saturating direction counter states.
// Optional feature macro (used by branch_predictor): BP_PERF_CNT_EN.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'd0,
        WEAK_NT   = 2'd1,
        WEAK_T    = 2'd2,
        STRONG_T  = 2'd3
    } bht_cnt_e;

endpackage

// File: rtl/branch_predictor_bht_sat_counter.sv
// Next-state logic for one 2-bit saturating direction counter.
// Ports:
//   cur   in  current counter state
//   taken in  resolved outcome (1 = taken)
//   nxt   out counter state after training with taken
module bht_sat_counter
    import branch_predictor_pkg::*;
(
    input  bht_cnt_e cur,
    input  logic     taken,
    output bht_cnt_e nxt
);

    always_comb begin
        nxt = cur;
        case (cur)
            STRONG_NT: nxt = taken ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   nxt = taken ? WEAK_T   : STRONG_NT;
            WEAK_T:    nxt = taken ? STRONG_T : WEAK_NT;
            STRONG_T:  nxt = taken ? STRONG_T : WEAK_T;
            default:   nxt = cur;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT (2-bit counters) plus tagged BTB. Looked up combinationally
// with the fetch PC; trained by the decode-stage resolved branch, which also
// raises mispredict and supplies the redirect PC.
// Ports:
//   clk_i, rst_i                     clock, async active-high reset
//   if_pc_i                          fetch PC to look up
//   pred_taken_o, pred_next_pc_o     prediction for if_pc_i
//   upd_valid_i, upd_pc_i            resolved branch valid / its PC
//   upd_taken_i, upd_target_i        actual outcome / target
//   upd_pred_taken_i/_target_i       prediction that travelled with the branch
//   mispredict_o, redirect_pc_o      flush request and correct next PC
//   br_cnt_o, mispred_cnt_o          event counters (only with BP_PERF_CNT_EN)
// Macro BP_PERF_CNT_EN adds the two 32-bit performance counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] if_pc_i,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_next_pc_o,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [XLEN-1:0] upd_target_i,
    input  logic            upd_pred_taken_i,
    input  logic [XLEN-1:0] upd_pred_target_i,
    output logic            mispredict_o,
    output logic [XLEN-1:0] redirect_pc_o
`ifdef BP_PERF_CNT_EN
    ,
    output logic [31:0]     br_cnt_o,
    output logic [31:0]     mispred_cnt_o
`endif
);

    localparam int INDEX_W = $clog2(BHT_ENTRIES);
    localparam int TAG_W   = XLEN - INDEX_W - 2;

    logic [BHT_ENTRIES-1:0] validTbl;
    logic [1:0]             cntTbl    [BHT_ENTRIES];
    logic [TAG_W-1:0]       tagTbl    [BHT_ENTRIES];
    logic [XLEN-1:0]        targetTbl [BHT_ENTRIES];

    // Lookup: pure read of current table contents (no bypass from update).
    logic [INDEX_W-1:0] lkIdx;
    logic [TAG_W-1:0]   lkTag;
    logic               lkHit;

    assign lkIdx          = if_pc_i[INDEX_W+1:2];
    assign lkTag          = if_pc_i[XLEN-1:INDEX_W+2];
    assign lkHit          = validTbl[lkIdx] && (tagTbl[lkIdx] == lkTag);
    assign pred_taken_o   = lkHit && cntTbl[lkIdx][1];
    assign pred_next_pc_o = pred_taken_o ? targetTbl[lkIdx] : if_pc_i + XLEN'(4);

    // Update path
    logic [INDEX_W-1:0] updIdx;
    logic [TAG_W-1:0]   updTag;
    logic               updHit;
    bht_cnt_e           cntNext;

    assign updIdx = upd_pc_i[INDEX_W+1:2];
    assign updTag = upd_pc_i[XLEN-1:INDEX_W+2];
    assign updHit = validTbl[updIdx] && (tagTbl[updIdx] == updTag);

    bht_sat_counter uSatCnt (
        .cur   (bht_cnt_e'(cntTbl[updIdx])),
        .taken (upd_taken_i),
        .nxt   (cntNext)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            validTbl <= '0;
            for (int i = 0; i < BHT_ENTRIES; i++) cntTbl[i] <= WEAK_NT;
        end else if (upd_valid_i) begin
            if (upd_taken_i) begin
                validTbl[updIdx] <= 1'b1;
                // A fresh allocation (or replacement of another branch) starts weakly taken.
                cntTbl[updIdx]   <= updHit ? cntNext : WEAK_T;
            end else if (updHit) begin
                cntTbl[updIdx]   <= cntNext;
            end
        end
    end

    // Tag/target need no reset: they are only observed behind validTbl.
    always_ff @(posedge clk_i) begin
        if (upd_valid_i && upd_taken_i) begin
            tagTbl[updIdx]    <= updTag;
            targetTbl[updIdx] <= upd_target_i;
        end
    end

    assign mispredict_o  = upd_valid_i &&
                           ((upd_taken_i != upd_pred_taken_i) ||
                            (upd_taken_i && (upd_pred_target_i != upd_target_i)));
    assign redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + XLEN'(4);

`ifdef BP_PERF_CNT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            br_cnt_o      <= '0;
            mispred_cnt_o <= '0;
        end else begin
            if (upd_valid_i)  br_cnt_o      <= br_cnt_o + 32'd1;
            if (mispredict_o) mispred_cnt_o <= mispred_cnt_o + 32'd1;
        end
    end
`endif

endmodule
